// File: rtl/fp_div_issue_queue.sv
// In-order issue buffer in front of fp_div: queues div/sqrt ops and launches one
// at a time with a single-cycle start pulse, tracking the divider's busy window.
module fp_div_issue_queue #(
  parameter int W            = 32,
  parameter int LG_DEPTH     = 2,
  parameter int LG_ROB_WIDTH = 1,
  parameter int LG_PRF_WIDTH = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    enq_valid,
  output logic                    enq_ready,
  input  logic [W-1:0]            enq_a,
  input  logic [W-1:0]            enq_b,
  input  logic                    enq_is_sqrt,
  input  logic [LG_ROB_WIDTH-1:0] enq_rob_ptr,
  input  logic [LG_PRF_WIDTH-1:0] enq_dst_ptr,
  output logic                    div_start,
  output logic [W-1:0]            div_a,
  output logic [W-1:0]            div_b,
  output logic                    div_is_sqrt,
  output logic [LG_ROB_WIDTH-1:0] div_rob_ptr,
  output logic [LG_PRF_WIDTH-1:0] div_dst_ptr,
  input  logic                    div_active,
  output logic                    empty,
  output logic [LG_DEPTH:0]       count,
  output logic                    busy
);

  localparam int DEPTH = 1 << LG_DEPTH;

  typedef struct packed {
    logic [W-1:0]            a;
    logic [W-1:0]            b;
    logic                    is_sqrt;
    logic [LG_ROB_WIDTH-1:0] rob_ptr;
    logic [LG_PRF_WIDTH-1:0] dst_ptr;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUED = 2'd1,
    BUSY   = 2'd2
  } state_t;

  entry_t              mem_q [DEPTH];
  logic [LG_DEPTH:0]   head_q, head_d;
  logic [LG_DEPTH:0]   tail_q, tail_d;
  logic [LG_DEPTH:0]   count_q, count_d;
  state_t              state_q, state_d;
  logic                full_s;
  logic                do_enq_s;
  entry_t              head_entry_s;
  entry_t              wr_entry_s;

  assign full_s       = (head_q[LG_DEPTH-1:0] == tail_q[LG_DEPTH-1:0]) &&
                        (head_q[LG_DEPTH] != tail_q[LG_DEPTH]);
  assign empty        = (head_q == tail_q);
  assign enq_ready    = !full_s;
  assign do_enq_s     = enq_valid && !full_s && !flush;
  assign count        = count_q;
  assign busy         = (state_q != IDLE);
  assign head_entry_s = mem_q[head_q[LG_DEPTH-1:0]];
  assign wr_entry_s   = '{a: enq_a, b: enq_b, is_sqrt: enq_is_sqrt,
                          rob_ptr: enq_rob_ptr, dst_ptr: enq_dst_ptr};

  // Launch only from IDLE; div_active blocks a start while the divider still drains.
  assign div_start   = (state_q == IDLE) && !empty && !div_active && !flush;
  assign div_a       = head_entry_s.a;
  assign div_b       = head_entry_s.b;
  assign div_is_sqrt = head_entry_s.is_sqrt;
  assign div_rob_ptr = head_entry_s.rob_ptr;
  assign div_dst_ptr = head_entry_s.dst_ptr;

  // Next-state for pointers, occupancy count and issue FSM
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    state_d = state_q;
    if (flush) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      if (do_enq_s) begin
        tail_d = tail_q + (LG_DEPTH+1)'(1);
      end else begin
        tail_d = tail_q;
      end
      if (div_start) begin
        head_d = head_q + (LG_DEPTH+1)'(1);
      end else begin
        head_d = head_q;
      end
      if (do_enq_s && !div_start) begin
        count_d = count_q + (LG_DEPTH+1)'(1);
      end else if (!do_enq_s && div_start) begin
        count_d = count_q - (LG_DEPTH+1)'(1);
      end else begin
        count_d = count_q;
      end
    end
    // An op already launched is tracked to completion even across a flush.
    case (state_q)
      IDLE:    state_d = div_start ? ISSUED : IDLE;
      ISSUED:  state_d = BUSY;
      BUSY:    state_d = div_active ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Entry storage; contents are only meaningful between head and tail
  always_ff @(posedge clk) begin
    if (do_enq_s) begin
      mem_q[tail_q[LG_DEPTH-1:0]] <= wr_entry_s;
    end
  end

endmodule

// File: tb/tb_fp_div_issue_queue.sv
// Randomized scoreboard bench for fp_div_issue_queue with a queue-based reference
// model and a simple fp_div stand-in that raises div_active the cycle after start.
module tb_fp_div_issue_queue;

  logic        clk = 1'b0;
  logic        reset, flush, enq_valid, enq_ready;
  logic [31:0] enq_a, enq_b, div_a, div_b;
  logic        enq_is_sqrt, div_is_sqrt;
  logic [0:0]  enq_rob_ptr, enq_dst_ptr, div_rob_ptr, div_dst_ptr;
  logic        div_start, div_active, empty, busy;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        r;
    logic        d;
  } op_t;

  op_t mq[$];
  int  checks = 0;
  int  errors = 0;
  int  lat_cnt, lat_next;
  bit  force_hi, primed, m_busy, exp_start;
  int  m_age, sz;

  always #5 clk = ~clk;

  fp_div_issue_queue #(.W(32), .LG_DEPTH(2), .LG_ROB_WIDTH(1), .LG_PRF_WIDTH(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_a(enq_a), .enq_b(enq_b), .enq_is_sqrt(enq_is_sqrt),
    .enq_rob_ptr(enq_rob_ptr), .enq_dst_ptr(enq_dst_ptr),
    .div_start(div_start), .div_a(div_a), .div_b(div_b), .div_is_sqrt(div_is_sqrt),
    .div_rob_ptr(div_rob_ptr), .div_dst_ptr(div_dst_ptr),
    .div_active(div_active), .empty(empty), .count(count), .busy(busy)
  );

  // fp_div stand-in: active for lat_next cycles starting the cycle after start (0 = never)
  assign div_active = force_hi || (lat_cnt != 0);
  always @(posedge clk) begin
    if (reset) lat_cnt <= 0;
    else if (div_start) lat_cnt <= lat_next;
    else if (lat_cnt > 0) lat_cnt <= lat_cnt - 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model: compares outputs mid-cycle, then advances the model
  always @(negedge clk) begin
    sz = mq.size();
    exp_start = !m_busy && (sz > 0) && !div_active && !flush;
    if (primed) begin
      chk("count", 64'(count), 64'(sz));
      chk("empty", 64'(empty), 64'(sz == 0));
      chk("enq_ready", 64'(enq_ready), 64'(sz < 4));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("div_start", 64'(div_start), 64'(exp_start));
      if (div_start && exp_start) begin
        chk("div_a", 64'(div_a), 64'(mq[0].a));
        chk("div_b", 64'(div_b), 64'(mq[0].b));
        chk("div_is_sqrt", 64'(div_is_sqrt), 64'(mq[0].s));
        chk("div_rob_ptr", 64'(div_rob_ptr), 64'(mq[0].r));
        chk("div_dst_ptr", 64'(div_dst_ptr), 64'(mq[0].d));
      end
    end
    if (reset) begin
      mq.delete();
      m_busy = 1'b0;
      m_age  = 0;
      primed = 1'b1;
    end else if (primed) begin
      if (exp_start) begin
        void'(mq.pop_front());
        m_busy = 1'b1;
        m_age  = 0;
      end else if (m_busy) begin
        if (m_age == 0) m_age = 1;
        else if (!div_active) m_busy = 1'b0;
      end
      if (flush) mq.delete();
      else if (enq_valid && sz < 4)
        mq.push_back('{a: enq_a, b: enq_b, s: enq_is_sqrt, r: enq_rob_ptr, d: enq_dst_ptr});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand_op();
    enq_valid   = 1'b1;
    enq_a       = $urandom;
    enq_b       = $urandom;
    enq_is_sqrt = 1'($urandom_range(0, 1));
    enq_rob_ptr = 1'($urandom_range(0, 1));
    enq_dst_ptr = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0;
    enq_a = 32'd0; enq_b = 32'd0; enq_is_sqrt = 1'b0;
    enq_rob_ptr = 1'b0; enq_dst_ptr = 1'b0;
    lat_next = 2; force_hi = 1'b0; primed = 1'b0; m_busy = 1'b0; m_age = 0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // single known divide
    enq_valid = 1'b1; enq_a = 32'h4080_0000; enq_b = 32'h4000_0000;
    enq_is_sqrt = 1'b0; enq_rob_ptr = 1'b1; enq_dst_ptr = 1'b1;
    step();
    enq_valid = 1'b0;
    repeat (8) step();

    // fill while divider held active; fifth offer must be refused
    force_hi = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_rand_op();
      step();
    end
    enq_valid = 1'b0;
    repeat (2) step();
    force_hi = 1'b0; lat_next = 3;
    repeat (30) step();

    // divider that never raises active after start
    lat_next = 0;
    for (int i = 0; i < 2; i++) begin
      drive_rand_op();
      step();
    end
    enq_valid = 1'b0;
    repeat (10) step();

    // flush with one op in flight, three queued, and an offer in the same cycle
    lat_next = 6;
    for (int i = 0; i < 4; i++) begin
      drive_rand_op();
      step();
    end
    drive_rand_op();
    flush = 1'b1;
    step();
    flush = 1'b0; enq_valid = 1'b0;
    repeat (10) step();

    // random traffic: wrap, flushes, varying divider latency
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) drive_rand_op();
      else enq_valid = 1'b0;
      flush    = ($urandom_range(0, 31) == 0);
      lat_next = $urandom_range(0, 4);
      step();
    end
    flush = 1'b0; enq_valid = 1'b0;
    repeat (10) step();

    // reset while busy with queued ops
    lat_next = 8;
    for (int i = 0; i < 3; i++) begin
      drive_rand_op();
      step();
    end
    enq_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (5) step();

    // drain remaining work within a bounded budget
    lat_next = 2;
    for (int i = 0; i < 4; i++) begin
      drive_rand_op();
      step();
    end
    enq_valid = 1'b0;
    begin
      int n;
      n = 0;
      while ((mq.size() != 0 || m_busy) && n < 200) begin
        step();
        n++;
      end
      chk("drain_timeout", 64'(n < 200), 64'd1);
    end
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
